axi_lite_slave_regfile: RTL

AXI-Lite responder (slave) that terminates the AXI-Lite master's AR/R/AW/W/B channels and backs them with a register file of NUM_REGS word registers. Register contents and per-register write strobes are exported flat to user logic. Out-of-range accesses complete with SLVERR. Read and write channels run as independent FSMs.

---
 rtl/axil_pkg.sv | 23 ++
 rtl/axil_regfile.sv | 83 ++++++++
 rtl/axi_lite_slave_regfile.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite register-file responder.
//   resp_t     : AXI response codes driven on RRESP/BRESP
//   wr_state_t : write-channel FSM states
//   rd_state_t : read-channel FSM states
// Optional feature macro used by the users of this package: AXIL_SLAVE_WSTRB_EN.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_regfile.sv
// Register storage behind the AXI-Lite responder.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_wr_en           commit a write this cycle (address/data/strobes below)
//   i_wr_addr         byte address of the write
//   i_wr_data         write data
//   i_wr_strb         byte-lane enables (all ones when strobes are not used)
//   o_wr_ok           write address is in range (combinational)
//   i_rd_addr         byte address of the read
//   o_rd_data         read data, 0 when out of range (combinational)
//   o_rd_ok           read address is in range (combinational)
//   o_reg_q           all register contents, reg i at [i*DATA_W +: DATA_W]
//   o_reg_wr_pulse    bit i high for the cycle after reg i is written
// The byte-strobe feature (macro AXIL_SLAVE_WSTRB_EN) is handled in the top;
// this block always honours i_wr_strb.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic [DATA_W/8-1:0]          i_wr_strb,
  output logic                         o_wr_ok,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_rd_ok,
  output logic [NUM_REGS*DATA_W-1:0]   o_reg_q,
  output logic [NUM_REGS-1:0]          o_reg_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_words [NUM_REGS];

  // The full address is compared so that aliases above the register window
  // are rejected rather than wrapping onto a low register.
  assign w_wr_idx  = i_wr_addr[IDX_W+1:2];
  assign w_rd_idx  = i_rd_addr[IDX_W+1:2];
  assign o_wr_ok   = (i_wr_addr < ADDR_LIMIT);
  assign o_rd_ok   = (i_rd_addr < ADDR_LIMIT);
  assign o_rd_data = o_rd_ok ? w_words[w_rd_idx] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_word;
      logic              r_pulse;
      logic              w_sel;

      assign w_sel = i_wr_en & o_wr_ok & (w_wr_idx == IDX_W'(gi));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_word  <= '0;
          r_pulse <= 1'b0;
        end else begin
          // Pulse fires even when every strobe is 0: the write still happened.
          r_pulse <= w_sel;
          for (int b = 0; b < NB; b++) begin
            if (w_sel && i_wr_strb[b]) begin
              r_word[b*8 +: 8] <= i_wr_data[b*8 +: 8];
            end
          end
        end
      end

      assign w_words[gi]                   = r_word;
      assign o_reg_q[gi*DATA_W +: DATA_W]  = r_word;
      assign o_reg_wr_pulse[gi]            = r_pulse;
    end
  endgenerate

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI-Lite responder backed by a flat register file.
// Ports:
//   aclk, areset_n            clock, asynchronous active-low reset
//   AR*/R*                    read address / read data channels
//   AW*/W*/B*                 write address / write data / write response
//   WSTRB                     byte-lane strobes, only with AXIL_SLAVE_WSTRB_EN
//   reg_q                     register contents, reg i at [i*DATA_W +: DATA_W]
//   reg_wr_pulse              bit i high the cycle after reg i is written
// Optional feature macro: AXIL_SLAVE_WSTRB_EN (adds WSTRB; without it every
// write updates the full word).
// Read and write channels are independent FSMs; every AXI output is a flop.
module axi_lite_slave_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  input  logic [ADDR_W-1:0]           ARADDR,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [DATA_W-1:0]           RDATA,
  output logic [1:0]                  RRESP,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [ADDR_W-1:0]           AWADDR,
  input  logic                        WVALID,
  output logic                        WREADY,
  input  logic [DATA_W-1:0]           WDATA,
`ifdef AXIL_SLAVE_WSTRB_EN
  input  logic [DATA_W/8-1:0]         WSTRB,
`endif
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [1:0]                  BRESP,
  output logic [NUM_REGS*DATA_W-1:0]  reg_q,
  output logic [NUM_REGS-1:0]         reg_wr_pulse
);

  localparam int NB = DATA_W / 8;

  // ---------------- write channel ----------------
  wr_state_t         r_wstate;
  logic              r_awready, r_wready, r_aw_got, r_w_got, r_bvalid;
  resp_t             r_bresp;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_wr_fire, w_wr_ok;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [NB-1:0]     w_wr_strb;

  assign w_aw_hs   = AWVALID & r_awready;
  assign w_w_hs    = WVALID & r_wready;
  assign w_have_aw = r_aw_got | w_aw_hs;
  assign w_have_w  = r_w_got | w_w_hs;
  // The write commits on the edge where the second half arrives, using the
  // live bus value for whichever half is handshaking on this very edge.
  assign w_wr_fire = (r_wstate == W_IDLE) & w_have_aw & w_have_w;
  assign w_wr_addr = r_aw_got ? r_awaddr : AWADDR;
  assign w_wr_data = r_w_got ? r_wdata : WDATA;

`ifdef AXIL_SLAVE_WSTRB_EN
  logic [NB-1:0] r_wstrb;
  assign w_wr_strb = r_w_got ? r_wstrb : WSTRB;
`else
  assign w_wr_strb = '1;
`endif

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_fire) begin
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            if (w_aw_hs) begin
              r_aw_got <= 1'b1;
              r_awaddr <= AWADDR;
            end
            if (w_w_hs) begin
              r_w_got <= 1'b1;
              r_wdata <= WDATA;
            end
            // Also raises both readies on the first edge after reset.
            r_awready <= !w_have_aw;
            r_wready  <= !w_have_w;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

`ifdef AXIL_SLAVE_WSTRB_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wstrb <= '0;
    end else if (w_w_hs && !w_wr_fire) begin
      r_wstrb <= WSTRB;
    end
  end
`endif

  // ---------------- read channel ----------------
  rd_state_t         r_rstate;
  logic              r_arready, r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  resp_t             r_rresp;

  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_ok;

  // Read data is sampled from the register outputs before this edge's write
  // lands, so a same-edge read/write of one register returns the old value.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (ARVALID && r_arready) begin
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axil_regfile #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk          (aclk),
    .i_rst_n        (areset_n),
    .i_wr_en        (w_wr_fire),
    .i_wr_addr      (w_wr_addr),
    .i_wr_data      (w_wr_data),
    .i_wr_strb      (w_wr_strb),
    .o_wr_ok        (w_wr_ok),
    .i_rd_addr      (ARADDR),
    .o_rd_data      (w_rd_data),
    .o_rd_ok        (w_rd_ok),
    .o_reg_q        (reg_q),
    .o_reg_wr_pulse (reg_wr_pulse)
  );

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule
